// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter.
// Holds digit constants, the converter state type and the digit-count helpers.
package bcd_pkg;

   localparam int BCD_DIGIT_W   = 4;
   localparam int BCD_MAX_DIGIT = 9;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } convState_t;

   // Decimal digits needed for the largest DATA_W-bit value, plus one guard digit
   function automatic int bcdDigitsFor(input int width);
      int value;
      int n;
      value = (1 << width) - 1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (value > 0) begin
            n++;
            value = value / 10;
         end
      end
      return n + 1;
   endfunction

   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < 8; i++) begin
         if (i < n) p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   localparam int ADJ_MIN = (BCD_MAX_DIGIT + 1) / 2;

   logic w_adjust;

   assign w_adjust = (i_digit >= BCD_DIGIT_W'(ADJ_MIN));
   assign o_digit  = w_adjust ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per cycle,
// with a valid/ready handshake on both sides and an out-of-range error flag.
module bin2bcd_conv
   import bcd_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          error
);

   localparam int NEED_DIG = bcdDigitsFor(DATA_W);
   localparam int INT_DIG  = (NEED_DIG > DIGITS) ? NEED_DIG : DIGITS;
   localparam int FIELD_W  = INT_DIG * BCD_DIGIT_W;
   localparam int SR_W     = FIELD_W + DATA_W;
   localparam int OUT_W    = DIGITS * BCD_DIGIT_W;
   localparam int CNT_W    = $clog2(DATA_W + 1);
   localparam logic [31:0] LIMIT = 32'(pow10(DIGITS) - 1);

   convState_t         r_state;
   logic [SR_W-1:0]    r_shift;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_inReady;
   logic               r_outValid;
   logic [OUT_W-1:0]   r_bcd;
   logic               r_error;

   logic [SR_W-1:0]    w_adjusted;
   logic [SR_W-1:0]    w_shifted;
   logic               w_errIn;

   // The BCD field sits above the binary operand; correct every digit before the shift
   for (genvar d = 0; d < INT_DIG; d++) begin : g_digit
      bcd_add3 u_add3 (
         .i_digit (r_shift[DATA_W + d*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_adjusted[DATA_W + d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign w_adjusted[DATA_W-1:0] = r_shift[DATA_W-1:0];
   assign w_shifted = w_adjusted << 1;
   assign w_errIn   = (32'(bin) > LIMIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_bcd      <= '0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_shift   <= {{FIELD_W{1'b0}}, bin};
                  r_cnt     <= CNT_W'(DATA_W);
                  r_error   <= w_errIn;
                  r_inReady <= 1'b0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt - CNT_W'(1);
               // Final step: publish the low digits, or zeros for an out-of-range operand
               if (r_cnt == CNT_W'(1)) begin
                  r_bcd      <= r_error ? '0 : w_shifted[DATA_W +: OUT_W];
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_inReady  <= 1'b1;
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign bcd       = r_bcd;
   assign error     = r_error;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed, table-driven bench for bin2bcd_conv with a decimal reference model
// and hand-written sequences for back-pressure, back-to-back and reset cases.
module tb_bin2bcd_conv;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  bin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] bcd;
   logic        error;

   int checks;
   int failures;

   typedef struct {
      logic [9:0]  bin;
      logic [11:0] expBcd;
      logic        expErr;
   } vec_t;

   vec_t vecs[11];

   bin2bcd_conv #(.DATA_W(10), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] refModel(input int v);
      logic [11:0] r;
      if (v > 999) return {1'b1, 12'h000};
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return {1'b0, r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Full transaction with out_ready held high: latency, result and one-cycle pulse
   task automatic applyStimulus(input logic [9:0] b, input logic [11:0] eb, input logic ee,
                                input string name);
      int waitCnt;
      int lat;
      @(negedge clk);
      waitCnt = 0;
      while (!in_ready && waitCnt < 40) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput({name, " accept_timeout"}, 32'(in_ready), 32'd1);
         return;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      bin       = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput({name, " latency"}, 32'(lat), 32'd10);
      checkOutput({name, " bcd"}, 32'(bcd), 32'(eb));
      checkOutput({name, " error"}, 32'(error), 32'(ee));
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, " pulse_end"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int r1, r2, t, lat, prevOv, seen;
      logic [12:0] m;

      checks   = 0;
      failures = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      bin       = '0;

      vecs[0]  = '{10'd255,  12'h255, 1'b0};
      vecs[1]  = '{10'd999,  12'h999, 1'b0};
      vecs[2]  = '{10'd1000, 12'h000, 1'b1};
      vecs[3]  = '{10'd1023, 12'h000, 1'b1};
      vecs[4]  = '{10'd0,    12'h000, 1'b0};
      vecs[5]  = '{10'd47,   12'h047, 1'b0};
      vecs[6]  = '{10'd512,  12'h512, 1'b0};
      vecs[7]  = '{10'd1,    12'h001, 1'b0};
      vecs[8]  = '{10'd100,  12'h100, 1'b0};
      vecs[9]  = '{10'd9,    12'h009, 1'b0};
      vecs[10] = '{10'd10,   12'h010, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset bcd", 32'(bcd), 32'd0);
      checkOutput("reset error", 32'(error), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].bin, vecs[i].expBcd, vecs[i].expErr, $sformatf("vec%0d", i));
      end

      // Back-to-back: in_valid held high, result period must be DATA_W+2
      @(negedge clk);
      in_valid = 1'b1;
      bin = 10'd0;
      r1 = -1;
      r2 = -1;
      t = 0;
      prevOv = 0;
      while (r2 < 0 && t < 60) begin
         @(posedge clk);
         t++;
         @(negedge clk);
         if (out_valid && prevOv == 0) begin
            if (r1 < 0) r1 = t;
            else r2 = t;
            checkOutput("b2b bcd", 32'(bcd), 32'd0);
         end
         prevOv = int'(out_valid);
      end
      in_valid = 1'b0;
      checkOutput("b2b first_rise", 32'(r1), 32'd11);
      checkOutput("b2b period", 32'(r2 - r1), 32'd12);

      // Back-pressure: hold result, ignore in_valid in DONE, re-accept after release
      applyStimulus(10'd5, 12'h005, 1'b0, "pre_bp");
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      bin       = 10'd47;
      @(posedge clk);
      @(negedge clk);
      bin = 10'd12;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("bp latency", 32'(lat), 32'd10);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("bp hold%0d valid", c), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp hold%0d bcd", c), 32'(bcd), 32'h047);
         checkOutput($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp release valid", 32'(out_valid), 32'd0);
      checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("bp reaccept in_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("bp reaccept latency", 32'(lat), 32'd10);
      checkOutput("bp reaccept bcd", 32'(bcd), 32'h012);
      @(posedge clk);
      @(negedge clk);

      // Reset in the middle of converting 512 must abort with no result
      in_valid = 1'b1;
      bin = 10'd512;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset bcd", 32'(bcd), 32'd0);
      checkOutput("midreset error", 32'(error), 32'd0);
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("midreset no_result", 32'(seen), 32'd0);

      // Reset and in_valid on the same edge: no accept
      rst_n    = 1'b0;
      in_valid = 1'b1;
      bin      = 10'd7;
      @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      checkOutput("rst_vs_valid in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (14) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("rst_vs_valid no_result", 32'(seen), 32'd0);

      // Sweep the whole operand range against the decimal model
      for (int v = 0; v < 1024; v++) begin
         m = refModel(v);
         applyStimulus(10'(v), m[11:0], m[12], $sformatf("sweep%0d", v));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
